axis_bram_acq_ctrl: RTL and testbench

Acquisition controller that sequences circular BRAM capture of an AXI-Stream sample source, with configurable pre-trigger and post-trigger depth. Software arms it. It fills the pre-trigger history, waits for a trigger, captures the post-trigger beats, then stops and reports the trigger address so software can unroll the ring. It sits between the ADC/DSP stream and a BRAM port, in place of a free-running writer, with cfg/sts on the register hub.

---
 rtl/axis_bram_acq_ctrl_pkg.sv | 12 +
 rtl/axis_bram_acq_ctrl.sv | 147 ++++++++++++++
 tb/tb_axis_bram_acq_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_bram_acq_ctrl_pkg.sv
// Shared types for the AXI-Stream to BRAM acquisition controller.
package axis_bram_acq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_e;

endpackage

// File: rtl/axis_bram_acq_ctrl.sv
// Pre/post-trigger ring capture of an AXI-Stream source into a BRAM port.
module axis_bram_acq_ctrl
  import axis_bram_acq_ctrl_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BRAM_DATA_WIDTH  = 32,
  parameter int unsigned BRAM_ADDR_WIDTH  = 10
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_pre,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_post,
  input  logic                         arm,
  input  logic                         trig,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_addr,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_trig_addr,
  output logic                         sts_busy,
  output logic                         sts_done,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic                         b_bram_clk,
  output logic                         b_bram_rst,
  output logic                         b_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = {{(BRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BRAM_ADDR_WIDTH:0]   CNT_ONE  = {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};

  acq_state_e                 state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BRAM_ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [BRAM_ADDR_WIDTH-1:0] cfg_pre_l_q, cfg_pre_l_d;
  logic [BRAM_ADDR_WIDTH-1:0] cfg_post_l_q, cfg_post_l_d;
  // One bit wider than the address so a full-scale cfg value cannot wrap.
  logic [BRAM_ADDR_WIDTH:0]   pre_cnt_q, pre_cnt_d;
  logic [BRAM_ADDR_WIDTH:0]   post_cnt_q, post_cnt_d;
  logic                       bram_wr;

  // Ring write strobe: every valid beat while a capture is in progress.
  always_comb begin
    bram_wr = s_axis_tvalid &&
              ((state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST));
  end

  // Next-state, address and counter logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    trig_addr_d  = trig_addr_q;
    cfg_pre_l_d  = cfg_pre_l_q;
    cfg_post_l_d = cfg_post_l_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;

    if (bram_wr) begin
      addr_d = addr_q + ADDR_ONE;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d      = ST_PRE;
          cfg_pre_l_d  = cfg_pre;
          cfg_post_l_d = cfg_post;
          addr_d       = '0;
          trig_addr_d  = '0;
          pre_cnt_d    = '0;
          post_cnt_d   = '0;
        end
      end
      ST_PRE: begin
        if (bram_wr) begin
          pre_cnt_d = pre_cnt_q + CNT_ONE;
        end
        if (pre_cnt_q == {1'b0, cfg_pre_l_q}) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (trig) begin
          trig_addr_d = addr_q;
          // A beat written alongside the trigger is post beat 0; with a zero
          // post depth that single beat already completes the capture.
          if (bram_wr) begin
            post_cnt_d = CNT_ONE;
            state_d    = (cfg_post_l_q == '0) ? ST_DONE : ST_POST;
          end else begin
            post_cnt_d = '0;
            state_d    = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (bram_wr) begin
          post_cnt_d = post_cnt_q + CNT_ONE;
          if (post_cnt_q == {1'b0, cfg_post_l_q}) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      trig_addr_q  <= '0;
      cfg_pre_l_q  <= '0;
      cfg_post_l_q <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      trig_addr_q  <= trig_addr_d;
      cfg_pre_l_q  <= cfg_pre_l_d;
      cfg_post_l_q <= cfg_post_l_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
    end
  end

  // Status decode and BRAM port wiring.
  always_comb begin
    sts_addr      = addr_q;
    sts_trig_addr = trig_addr_q;
    sts_busy      = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    sts_done      = (state_q == ST_DONE);
    s_axis_tready = 1'b1;
    b_bram_clk    = aclk;
    b_bram_rst    = areset;
    b_bram_en     = bram_wr;
    b_bram_we     = {(BRAM_DATA_WIDTH/8){bram_wr}};
    b_bram_addr   = addr_q;
    b_bram_wdata  = s_axis_tdata;
  end

endmodule

// File: tb/tb_axis_bram_acq_ctrl.sv
// Directed scoreboard bench for axis_bram_acq_ctrl with a 16-entry ring.
module tb_axis_bram_acq_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          aclk;
  logic          areset;
  logic [AW-1:0] cfg_pre;
  logic [AW-1:0] cfg_post;
  logic          arm;
  logic          trig;
  logic [AW-1:0] sts_addr;
  logic [AW-1:0] sts_trig_addr;
  logic          sts_busy;
  logic          sts_done;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          b_bram_clk;
  logic          b_bram_rst;
  logic          b_bram_en;
  logic [DW/8-1:0] b_bram_we;
  logic [AW-1:0] b_bram_addr;
  logic [DW-1:0] b_bram_wdata;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [DW-1:0] dseq = 32'hC0DE_0000;

  axis_bram_acq_ctrl #(
    .AXIS_TDATA_WIDTH(DW),
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_pre      (cfg_pre),
    .cfg_post     (cfg_post),
    .arm          (arm),
    .trig         (trig),
    .sts_addr     (sts_addr),
    .sts_trig_addr(sts_trig_addr),
    .sts_busy     (sts_busy),
    .sts_done     (sts_done),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .b_bram_clk   (b_bram_clk),
    .b_bram_rst   (b_bram_rst),
    .b_bram_en    (b_bram_en),
    .b_bram_we    (b_bram_we),
    .b_bram_addr  (b_bram_addr),
    .b_bram_wdata (b_bram_wdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; ea >= 0 means a BRAM write to ea is expected.
  task automatic beat(input logic v, input logic t, input int ea);
    exp_t e;
    dseq          = dseq + 32'd1;
    s_axis_tdata  = dseq;
    s_axis_tvalid = v;
    trig          = t;
    if (v && ea >= 0) begin
      e.addr = AW'(ea);
      e.data = dseq;
      exp_q.push_back(e);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    trig          = 1'b0;
  endtask

  task automatic do_arm(input logic [AW-1:0] pre, input logic [AW-1:0] post);
    cfg_pre  = pre;
    cfg_post = post;
    arm      = 1'b1;
    beat(1'b0, 1'b0, -1);
    arm      = 1'b0;
    cfg_pre  = '1;
    cfg_post = '1;
  endtask

  // Write monitor: every BRAM write must match the next expected beat.
  always @(negedge aclk) begin
    if (b_bram_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h, no write expected",
                 b_bram_addr, b_bram_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (b_bram_addr !== e.addr || b_bram_wdata !== e.data || b_bram_we !== 4'hF
            || s_axis_tready !== 1'b1) begin
          failures++;
          $display("FAIL bram_write: got addr %0h data %0h we %0h rdy %0b, expected addr %0h data %0h we f rdy 1",
                   b_bram_addr, b_bram_wdata, b_bram_we, s_axis_tready, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset        = 1'b1;
    cfg_pre       = '0;
    cfg_post      = '0;
    arm           = 1'b0;
    trig          = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    areset = 1'b0;
    chk("reset_busy", 32'(sts_busy), 32'd0);
    chk("reset_done", 32'(sts_done), 32'd0);
    chk("reset_addr", 32'(sts_addr), 32'd0);
    chk("reset_trig_addr", 32'(sts_trig_addr), 32'd0);
    chk("reset_bram_rst", 32'(b_bram_rst), 32'd0);

    // Beats while idle are discarded.
    beat(1'b1, 1'b1, -1);
    chk("idle_busy", 32'(sts_busy), 32'd0);

    // Basic capture: pre 3, post 2, trigger at addr 5.
    do_arm(4'd3, 4'd2);
    chk("s1_busy_after_arm", 32'(sts_busy), 32'd1);
    for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, i);
    beat(1'b1, 1'b1, 5);
    beat(1'b1, 1'b0, 6);
    chk("s1_busy_post", 32'(sts_busy), 32'd1);
    beat(1'b1, 1'b0, 7);
    chk("s1_done", 32'(sts_done), 32'd1);
    chk("s1_busy_off", 32'(sts_busy), 32'd0);
    chk("s1_trig_addr", 32'(sts_trig_addr), 32'd5);
    chk("s1_addr", 32'(sts_addr), 32'd8);
    beat(1'b1, 1'b0, -1);
    beat(1'b1, 1'b1, -1);
    chk("s1_addr_hold", 32'(sts_addr), 32'd8);

    // Zero depths, trigger with a beat: exactly two writes.
    do_arm(4'd0, 4'd0);
    beat(1'b1, 1'b0, 0);
    beat(1'b1, 1'b1, 1);
    chk("s2_done", 32'(sts_done), 32'd1);
    chk("s2_trig_addr", 32'(sts_trig_addr), 32'd1);
    chk("s2_addr", 32'(sts_addr), 32'd2);
    beat(1'b1, 1'b0, -1);

    // Trigger during PRE is ignored; arm during WAIT is ignored.
    do_arm(4'd5, 4'd1);
    beat(1'b1, 1'b0, 0);
    beat(1'b1, 1'b0, 1);
    beat(1'b1, 1'b1, 2);
    beat(1'b1, 1'b0, 3);
    beat(1'b1, 1'b0, 4);
    beat(1'b1, 1'b0, 5);
    chk("s3_busy_wait", 32'(sts_busy), 32'd1);
    chk("s3_done_wait", 32'(sts_done), 32'd0);
    chk("s3_trig_addr_untouched", 32'(sts_trig_addr), 32'd0);
    arm = 1'b1;
    beat(1'b1, 1'b0, 6);
    arm = 1'b0;
    beat(1'b1, 1'b0, 7);
    beat(1'b0, 1'b1, -1);
    chk("s3_trig_addr", 32'(sts_trig_addr), 32'd8);
    beat(1'b1, 1'b0, 8);
    beat(1'b0, 1'b0, -1);
    chk("s3_busy_post", 32'(sts_busy), 32'd1);
    beat(1'b1, 1'b0, 9);
    chk("s3_done", 32'(sts_done), 32'd1);
    chk("s3_addr", 32'(sts_addr), 32'd10);

    // Ring wrap: 20 beats in WAIT before the trigger.
    do_arm(4'd3, 4'd3);
    for (int i = 0; i < 24; i++) beat(1'b1, 1'b0, i % 16);
    chk("s4_busy_wrapped", 32'(sts_busy), 32'd1);
    beat(1'b1, 1'b1, 8);
    beat(1'b1, 1'b0, 9);
    beat(1'b1, 1'b0, 10);
    beat(1'b1, 1'b0, 11);
    chk("s4_done", 32'(sts_done), 32'd1);
    chk("s4_trig_addr", 32'(sts_trig_addr), 32'd8);
    chk("s4_addr", 32'(sts_addr), 32'd12);

    // Gapped stream through POST.
    do_arm(4'd1, 4'd2);
    beat(1'b1, 1'b0, 0);
    beat(1'b1, 1'b0, 1);
    beat(1'b1, 1'b1, 2);
    beat(1'b0, 1'b0, -1);
    beat(1'b0, 1'b0, -1);
    beat(1'b1, 1'b0, 3);
    chk("s5_busy_mid", 32'(sts_busy), 32'd1);
    chk("s5_addr_mid", 32'(sts_addr), 32'd4);
    beat(1'b0, 1'b0, -1);
    beat(1'b0, 1'b0, -1);
    beat(1'b1, 1'b0, 4);
    chk("s5_done", 32'(sts_done), 32'd1);
    chk("s5_trig_addr", 32'(sts_trig_addr), 32'd2);
    chk("s5_addr", 32'(sts_addr), 32'd5);

    // Reset in POST, then a fresh capture with new depths.
    do_arm(4'd2, 4'd4);
    beat(1'b1, 1'b0, 0);
    beat(1'b1, 1'b0, 1);
    beat(1'b1, 1'b0, 2);
    beat(1'b1, 1'b1, 3);
    beat(1'b1, 1'b0, 4);
    areset = 1'b1;
    beat(1'b1, 1'b0, 5);
    areset = 1'b0;
    chk("s6_busy_reset", 32'(sts_busy), 32'd0);
    chk("s6_done_reset", 32'(sts_done), 32'd0);
    chk("s6_addr_reset", 32'(sts_addr), 32'd0);
    chk("s6_trig_addr_reset", 32'(sts_trig_addr), 32'd0);
    beat(1'b1, 1'b0, -1);
    do_arm(4'd1, 4'd0);
    beat(1'b1, 1'b0, 0);
    beat(1'b1, 1'b0, 1);
    beat(1'b1, 1'b1, 2);
    chk("s6_done", 32'(sts_done), 32'd1);
    chk("s6_trig_addr", 32'(sts_trig_addr), 32'd2);
    chk("s6_addr", 32'(sts_addr), 32'd3);

    beat(1'b0, 1'b0, -1);
    chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
